control_fsm: RTL and testbench



---
 rtl/control_fsm_if.sv | 25 ++
 rtl/control_fsm.sv | 128 ++++++++++++
 tb/tb_control_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Bus between the control FSM and its consumers: the opcode goes in; state and
// status come out.
interface control_fsm_if;
   logic [15:0] opcode;
   logic [4:0]  state;
   logic        halted;
   logic        illegal_op;
   logic [15:0] instr_retired;

   modport master (
      input  opcode,
      output state,
      output halted,
      output illegal_op,
      output instr_retired
   );

   modport slave (
      output opcode,
      input  state,
      input  halted,
      input  illegal_op,
      input  instr_retired
   );
endinterface

// File: rtl/control_fsm.sv
// Control state machine for the 16-bit CPU core: fetch/decode/execute sequencing,
// halt and illegal-opcode reporting, and a count of retired instructions.
module control_fsm (
   input  logic          clk,
   input  logic          rst_n,
   control_fsm_if.master bus
);

   typedef enum logic [4:0] {
      S_RESET           = 5'd0,
      S_FETCH_1         = 5'd1,
      S_FETCH_2         = 5'd2,
      S_DECODE          = 5'd3,
      S_ALU_OPERATION   = 5'd4,
      S_ALU_IMMEDIATE   = 5'd5,
      S_STORE_RESULT_1  = 5'd6,
      S_STORE_RESULT_2  = 5'd7,
      S_COPY_REGISTER   = 5'd8,
      S_FETCH_IMMEDIATE = 5'd9,
      S_FETCH_ADDRESS_1 = 5'd10,
      S_FETCH_ADDRESS_2 = 5'd11,
      S_FETCH_ADDRESS_3 = 5'd12,
      S_FETCH_ADDRESS_4 = 5'd13,
      S_FETCH_MEMORY    = 5'd14,
      S_STORE_MEMORY    = 5'd15,
      S_TEMP_FETCH      = 5'd16,
      S_TEMP_STORE      = 5'd17,
      S_LOAD_JUMP_1     = 5'd18,
      S_LOAD_JUMP_2     = 5'd19,
      S_EXECUTE_JUMP    = 5'd20,
      S_HALT            = 5'd31
   } state_t;

   localparam logic [4:0] C_MULTIPLY = 5'b00110;
   localparam logic [4:0] C_MOVE     = 5'b10000;
   localparam logic [4:0] C_LOAD     = 5'b10001;
   localparam logic [4:0] C_STORE    = 5'b10010;
   localparam logic [4:0] C_JUMP     = 5'b10011;
   localparam logic [4:0] C_NOP      = 5'b10100;
   localparam logic [4:0] C_HALT     = 5'b11111;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] retired_q;
   logic        illegal;
   logic        retire;
   logic [4:0]  op_class;
   logic [1:0]  op_mode;
   logic        unused_bits;

   assign op_class    = bus.opcode[15:11];
   assign op_mode     = bus.opcode[10:9];
   assign unused_bits = ^bus.opcode[8:0];

   always_comb begin
      state_d = S_FETCH_1;
      illegal = 1'b0;
      case (state_q)
         S_RESET:   state_d = S_FETCH_1;
         S_FETCH_1: state_d = S_FETCH_2;
         S_FETCH_2: state_d = S_DECODE;
         S_DECODE: begin
            if (!op_class[4]) begin
               case (op_mode)
                  2'b00:   state_d = S_ALU_OPERATION;
                  2'b01:   state_d = S_ALU_IMMEDIATE;
                  2'b10:   state_d = S_FETCH_ADDRESS_1;
                  default: illegal = 1'b1;
               endcase
            end else begin
               case (op_class)
                  C_MOVE:  state_d = S_COPY_REGISTER;
                  C_LOAD: begin
                     if (op_mode == 2'b00)      state_d = S_FETCH_IMMEDIATE;
                     else if (op_mode == 2'b01) state_d = S_FETCH_ADDRESS_1;
                     else                       illegal = 1'b1;
                  end
                  C_STORE: state_d = S_FETCH_ADDRESS_1;
                  C_JUMP:  state_d = S_LOAD_JUMP_1;
                  C_NOP:   state_d = S_FETCH_1;
                  C_HALT:  state_d = S_HALT;
                  default: illegal = 1'b1;
               endcase
            end
         end
         S_ALU_OPERATION,
         S_ALU_IMMEDIATE:   state_d = S_STORE_RESULT_1;
         S_STORE_RESULT_1:  state_d = (op_class == C_MULTIPLY) ? S_STORE_RESULT_2 : S_FETCH_1;
         S_FETCH_ADDRESS_1: state_d = S_FETCH_ADDRESS_2;
         // Shared address state: the held opcode picks which memory path follows.
         S_FETCH_ADDRESS_2: begin
            if (!op_class[4])           state_d = S_TEMP_FETCH;
            else if (op_class == C_LOAD)  state_d = S_FETCH_MEMORY;
            else if (op_class == C_STORE) state_d = S_STORE_MEMORY;
            else                          state_d = S_FETCH_1;
         end
         S_TEMP_FETCH:      state_d = S_FETCH_ADDRESS_3;
         S_FETCH_ADDRESS_3: state_d = S_FETCH_ADDRESS_4;
         S_FETCH_ADDRESS_4: state_d = S_TEMP_STORE;
         S_LOAD_JUMP_1:     state_d = S_LOAD_JUMP_2;
         S_LOAD_JUMP_2:     state_d = S_EXECUTE_JUMP;
         S_HALT:            state_d = S_HALT;
         default:           state_d = S_FETCH_1;
      endcase
   end

   // Retire on every return to fetch except the one out of reset, and once on halt entry.
   assign retire = ((state_d == S_FETCH_1) && (state_q != S_RESET)) ||
                   ((state_d == S_HALT) && (state_q != S_HALT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RESET;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) retired_q <= retired_q + 16'd1;
      end
   end

   always_comb begin
      bus.state         = state_q;
      bus.halted        = (state_q == S_HALT);
      bus.illegal_op    = (state_q == S_DECODE) && illegal;
      bus.instr_retired = retired_q;
   end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: directed opcodes push hand-written state
// paths into a queue; a negedge monitor pops and compares every cycle.
module tb_control_fsm;

   typedef struct packed {
      logic [15:0] op;
      logic [4:0]  st;
      logic        ill;
      logic        hlt;
      logic [15:0] ret;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cnt;
   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];

   control_fsm_if bus_i ();

   control_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endfunction

   // Monitor: the DUT presents a state every cycle; compare whenever one is expected.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus_i.state !== e.st || bus_i.illegal_op !== e.ill ||
                bus_i.halted !== e.hlt || bus_i.instr_retired !== e.ret) begin
               errors++;
               $display("FAIL op %h: got st=%0d ill=%b hlt=%b ret=%h, required st=%0d ill=%b hlt=%b ret=%h",
                        e.op, bus_i.state, bus_i.illegal_op, bus_i.halted, bus_i.instr_retired,
                        e.st, e.ill, e.hlt, e.ret);
            end
         end
      end
   end

   task automatic drain();
      int unsigned n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
         q.delete();
      end
   endtask

   // Called one time unit after the edge that entered S_FETCH_1.
   task automatic run(input logic [15:0] op, input bit ill,
                      input int p3 = -1, input int p4 = -1, input int p5 = -1,
                      input int p6 = -1, input int p7 = -1, input int p8 = -1);
      int path[$];
      path = '{1, 2, 3};
      if (p3 >= 0) path.push_back(p3);
      if (p4 >= 0) path.push_back(p4);
      if (p5 >= 0) path.push_back(p5);
      if (p6 >= 0) path.push_back(p6);
      if (p7 >= 0) path.push_back(p7);
      if (p8 >= 0) path.push_back(p8);
      bus_i.opcode = op;
      foreach (path[i])
         q.push_back('{op: op, st: 5'(path[i]), ill: (ill && path[i] == 3),
                       hlt: 1'b0, ret: cnt});
      drain();
      cnt = cnt + 16'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus_i.opcode = 16'hA000;
      cnt = '0;
      #1;
      chk("reset_state", 16'(bus_i.state), 16'd0);
      chk("reset_retired", bus_i.instr_retired, 16'h0000);
      chk("reset_halted", 16'(bus_i.halted), 16'd0);
      chk("reset_illegal", 16'(bus_i.illegal_op), 16'd0);
      repeat (2) @(negedge clk);
      chk("reset_held", 16'(bus_i.state), 16'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(16'hA000, 0);
      run(16'hA000, 0);
      run(16'hA000, 0);

      // Mid-instruction reset: abort in S_FETCH_2, nothing counted.
      bus_i.opcode = 16'hA000;
      @(posedge clk);
      #1;
      chk("pre_abort_state", 16'(bus_i.state), 16'd2);
      chk("pre_abort_retired", bus_i.instr_retired, cnt);
      rst_n = 1'b0;
      #1;
      chk("abort_state", 16'(bus_i.state), 16'd0);
      chk("abort_retired", bus_i.instr_retired, 16'h0000);
      cnt = '0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(16'hA000, 0);
      run(16'h0000, 0, 4, 6);                 // add
      run(16'h3000, 0, 4, 6, 7);              // multiply
      run(16'h0200, 0, 5, 6);                 // immediate ALU
      run(16'h3200, 0, 5, 6, 7);              // immediate multiply
      run(16'h8000, 0, 8);                    // move
      run(16'h8800, 0, 9);                    // load immediate
      run(16'h8A00, 0, 10, 11, 14);           // load memory
      run(16'h9000, 0, 10, 11, 15);           // store
      run(16'h0400, 0, 10, 11, 16, 12, 13, 17);
      run(16'h3400, 0, 10, 11, 16, 12, 13, 17);
      for (int unsigned j = 0; j < 4; j++)
         run(16'h9800 | 16'(j), 0, 18, 19, 20);
      run(16'hB000, 1);                       // undefined class
      run(16'h0600, 1);                       // ALU mode 11
      run(16'h8C00, 1);                       // LOAD mode 10
      run(16'h8E00, 1);                       // LOAD mode 11
      run(16'hA000, 0);

      // Counter wrap: preload the count, then two more retirements.
      force dut.retired_q = 16'hFFFF;
      #1 release dut.retired_q;
      cnt = 16'hFFFF;
      run(16'hA000, 0);
      run(16'hA000, 0);

      // Halt: entered once, counted once, held.
      bus_i.opcode = 16'hF800;
      for (int i = 0; i < 3; i++)
         q.push_back('{op: 16'hF800, st: 5'(i + 1), ill: 1'b0, hlt: 1'b0, ret: cnt});
      for (int i = 0; i < 100; i++)
         q.push_back('{op: 16'hF800, st: 5'd31, ill: 1'b0, hlt: 1'b1, ret: cnt + 16'd1});
      drain();
      bus_i.opcode = 16'hA000;
      @(negedge clk);
      chk("halt_after_opcode_change", 16'(bus_i.state), 16'd31);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
